// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD read ports, two write ports, busy scoreboard, Clear sweep.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_RD*ADDR_W-1:0]   R_Addr,
    output logic [NUM_RD*DATA_W-1:0]   R_Data,
    output logic [NUM_RD-1:0]          R_Busy,
    input  logic                       W0_En,
    input  logic [ADDR_W-1:0]          W0_Addr,
    input  logic [DATA_W-1:0]          W0_Data,
    input  logic                       W1_En,
    input  logic [ADDR_W-1:0]          W1_Addr,
    input  logic [DATA_W-1:0]          W1_Data,
    input  logic                       Issue_En,
    input  logic [ADDR_W-1:0]          Issue_Addr,
    input  logic                       Clear,
    output logic                       Ready
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]   busy;
    logic [ADDR_W-1:0]  ptr;
    logic               w0_ok, w1_ok, iss_ok;

    assign Ready = (state == IDLE);

    // Effective requests: only accepted while idle, and never to entry 0 when it is hardwired.
    assign w0_ok  = W0_En    && Ready && !(ZERO_REG != 0 && W0_Addr    == '0);
    assign w1_ok  = W1_En    && Ready && !(ZERO_REG != 0 && W1_Addr    == '0);
    assign iss_ok = Issue_En && Ready && !(ZERO_REG != 0 && Issue_Addr == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Clear) state_nxt = SWEEP;
            SWEEP:   if (ptr == '1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i[ADDR_W-1:0]] <= '0;
        end else begin
            state <= state_nxt;
            if (state == SWEEP) begin
                mem[ptr]  <= '0;
                busy[ptr] <= 1'b0;
                ptr       <= ptr + 1'b1;
            end else begin
                if (state_nxt == SWEEP)
                    ptr <= '0;
                // Later assignments win: W1 over W0, and a same-cycle issue re-marks busy.
                if (w0_ok) begin
                    mem[W0_Addr]  <= W0_Data;
                    busy[W0_Addr] <= 1'b0;
                end
                if (w1_ok) begin
                    mem[W1_Addr]  <= W1_Data;
                    busy[W1_Addr] <= 1'b0;
                end
                if (iss_ok)
                    busy[Issue_Addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;

        assign a = R_Addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            d = mem[a];
            b = busy[a];
`ifdef REGFILE_BYPASS_EN
            if (w0_ok && W0_Addr == a) begin
                d = W0_Data;
                b = iss_ok && (Issue_Addr == a);
            end
            if (w1_ok && W1_Addr == a) begin
                d = W1_Data;
                b = iss_ok && (Issue_Addr == a);
            end
`endif
            if (ZERO_REG != 0 && a == '0) begin
                d = '0;
                b = 1'b0;
            end
        end

        assign R_Data[k*DATA_W +: DATA_W] = d;
        assign R_Busy[k]                  = b;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: driver queues expected read results, negedge monitor checks them.
// Expectations for same-cycle reads follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_mp;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  R_Addr;
    logic [63:0] R_Data;
    logic [1:0]  R_Busy;
    logic        W0_En, W1_En, Issue_En, Clear, Ready;
    logic [4:0]  W0_Addr, W1_Addr, Issue_Addr;
    logic [31:0] W0_Data, W1_Data;

    logic [19:0]  R_Addr2;
    logic [127:0] R_Data2;
    logic [3:0]   R_Busy2;
    logic         W0_En2, Ready2;
    logic [4:0]   W0_Addr2;
    logic [31:0]  W0_Data2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        string       name;
        int unsigned dut;
        int          port;   // -1 selects the Ready output
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t sb[$];

    always #5 Clk = ~Clk;

    regfile_mp dut (
        .Clk(Clk), .Reset(Reset), .R_Addr(R_Addr), .R_Data(R_Data), .R_Busy(R_Busy),
        .W0_En(W0_En), .W0_Addr(W0_Addr), .W0_Data(W0_Data),
        .W1_En(W1_En), .W1_Addr(W1_Addr), .W1_Data(W1_Data),
        .Issue_En(Issue_En), .Issue_Addr(Issue_Addr), .Clear(Clear), .Ready(Ready)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)) dut4 (
        .Clk(Clk), .Reset(Reset), .R_Addr(R_Addr2), .R_Data(R_Data2), .R_Busy(R_Busy2),
        .W0_En(W0_En2), .W0_Addr(W0_Addr2), .W0_Data(W0_Data2),
        .W1_En(1'b0), .W1_Addr(5'd0), .W1_Data(32'd0),
        .Issue_En(1'b0), .Issue_Addr(5'd0), .Clear(1'b0), .Ready(Ready2)
    );

    // Monitor: drains all expectations queued for this cycle.
    always @(negedge Clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] ad;
            logic        ab;
            e = sb.pop_front();
            if (e.port < 0) begin
                ad = {31'd0, (e.dut == 0) ? Ready : Ready2};
                ab = e.busy;
            end else if (e.dut == 0) begin
                ad = R_Data[e.port*32 +: 32];
                ab = R_Busy[e.port];
            end else begin
                ad = R_Data2[e.port*32 +: 32];
                ab = R_Busy2[e.port];
            end
            checks++;
            if (ad !== e.data || ab !== e.busy) begin
                errors++;
                $display("FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                         e.name, ad, ab, e.data, e.busy);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        W0_En = 1'b0; W1_En = 1'b0; Issue_En = 1'b0; Clear = 1'b0; W0_En2 = 1'b0;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        R_Addr[p*5 +: 5] = a;
    endtask

    task automatic exp_rd(input string n, input int p, input logic [31:0] d, input logic b);
        sb.push_back('{name: n, dut: 0, port: p, data: d, busy: b});
    endtask

    task automatic exp_rdy(input string n, input logic r);
        sb.push_back('{name: n, dut: 0, port: -1, data: {31'd0, r}, busy: 1'b0});
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        W0_En = 1'b1; W0_Addr = a; W0_Data = d;
    endtask

    logic bp;

    initial begin
`ifdef REGFILE_BYPASS_EN
        bp = 1'b1;
`else
        bp = 1'b0;
`endif
        Reset = 1'b1; R_Addr = '0; R_Addr2 = '0;
        W0_Addr = '0; W0_Data = '0; W1_Addr = '0; W1_Data = '0; Issue_Addr = '0;
        W0_Addr2 = '0; W0_Data2 = '0;
        idle();
        tick(); tick();
        Reset = 1'b0;

        // Reset state across every address
        for (int i = 0; i < 32; i++) begin
            rd(0, 5'(i)); rd(1, 5'(31 - i));
            exp_rd("reset_p0", 0, 32'h0, 1'b0);
            exp_rd("reset_p1", 1, 32'h0, 1'b0);
            exp_rdy("reset_ready", 1'b1);
            tick();
        end

        // Dual write to the same address: W1 wins
        wr0(5'd5, 32'hDEADBEEF);
        W1_En = 1'b1; W1_Addr = 5'd5; W1_Data = 32'h12345678;
        rd(0, 5'd5);
        exp_rd("dual_wr_same_cycle", 0, bp ? 32'h12345678 : 32'h0, 1'b0);
        tick(); idle();
        exp_rd("dual_wr_w1_wins", 0, 32'h12345678, 1'b0);
        wr0(5'd0, 32'hFFFFFFFF); rd(1, 5'd0);
        exp_rd("r0_write_same_cycle", 1, 32'h0, 1'b0);
        tick(); idle();
        exp_rd("r0_reads_zero", 1, 32'h0, 1'b0);
        Issue_En = 1'b1; Issue_Addr = 5'd0;
        tick(); idle();
        exp_rd("r0_never_busy", 1, 32'h0, 1'b0);
        tick();

        // Busy scoreboard
        Issue_En = 1'b1; Issue_Addr = 5'd7; rd(0, 5'd7);
        exp_rd("issue_r7_same_cycle", 0, 32'h0, 1'b0);
        tick(); idle();
        exp_rd("issue_r7_busy", 0, 32'h0, 1'b1);
        wr0(5'd7, 32'h55);
        exp_rd("wr_r7_same_cycle", 0, bp ? 32'h55 : 32'h0, bp ? 1'b0 : 1'b1);
        tick(); idle();
        exp_rd("wr_r7_clears_busy", 0, 32'h55, 1'b0);
        Issue_En = 1'b1; Issue_Addr = 5'd9;
        W1_En = 1'b1; W1_Addr = 5'd9; W1_Data = 32'h99; rd(1, 5'd9);
        exp_rd("issue_wr_r9_same_cycle", 1, bp ? 32'h99 : 32'h0, bp ? 1'b1 : 1'b0);
        tick(); idle();
        exp_rd("issue_wr_r9_busy_kept", 1, 32'h99, 1'b1);
        Issue_En = 1'b1; Issue_Addr = 5'd9;
        tick(); idle();
        exp_rd("reissue_r9_busy", 1, 32'h99, 1'b1);
        tick();

        // Fill r1..r31, then sweep
        for (int i = 1; i < 32; i++) begin
            wr0(5'(i), 32'h1000 + 32'(i));
            tick();
        end
        idle();
        rd(0, 5'd3); rd(1, 5'd20);
        exp_rd("fill_r3", 0, 32'h1003, 1'b0);
        exp_rd("fill_r20", 1, 32'h1014, 1'b0);
        Clear = 1'b1;
        exp_rdy("ready_at_clear", 1'b1);
        tick(); Clear = 1'b0;
        for (int s = 0; s < 32; s++) begin
            if (s == 5) begin
                wr0(5'd20, 32'hBAD);
                Issue_En = 1'b1; Issue_Addr = 5'd20;
            end else if (s == 6) begin
                idle(); Clear = 1'b1;
            end else begin
                idle();
            end
            exp_rdy("ready_low_sweep", 1'b0);
            exp_rd("sweep_r3", 0, (s >= 4) ? 32'h0 : 32'h1003, 1'b0);
            exp_rd("sweep_r20", 1, (s >= 21) ? 32'h0 : 32'h1014, 1'b0);
            tick();
        end
        idle();
        exp_rdy("ready_after_sweep", 1'b1);
        exp_rd("post_sweep_r3", 0, 32'h0, 1'b0);
        exp_rd("post_sweep_r20", 1, 32'h0, 1'b0);
        tick();

        // Reset in the middle of a sweep
        wr0(5'd3, 32'h33);
        W1_En = 1'b1; W1_Addr = 5'd20; W1_Data = 32'h44;
        Issue_En = 1'b1; Issue_Addr = 5'd25;
        tick(); idle();
        exp_rd("pre_clear_r20", 1, 32'h44, 1'b0);
        Clear = 1'b1;
        tick(); Clear = 1'b0;
        for (int s = 0; s < 10; s++) tick();
        exp_rdy("ready_low_s10", 1'b0);
        rd(1, 5'd20);
        exp_rd("sweep_s10_r20_kept", 1, 32'h44, 1'b0);
        Reset = 1'b1;
        tick(); Reset = 1'b0;
        rd(0, 5'd25);
        exp_rdy("ready_after_abort", 1'b1);
        exp_rd("abort_r25_busy", 0, 32'h0, 1'b0);
        exp_rd("abort_r20", 1, 32'h0, 1'b0);
        tick();

        // Write-to-read bypass
        wr0(5'd4, 32'hA5A5A5A5); rd(1, 5'd4);
        exp_rd("bypass_r4_same_cycle", 1, bp ? 32'hA5A5A5A5 : 32'h0, 1'b0);
        tick(); idle();
        exp_rd("bypass_r4_next", 1, 32'hA5A5A5A5, 1'b0);
        tick();

        // Four read ports, entry 0 ordinary
        for (int i = 0; i < 4; i++) begin
            W0_En2 = 1'b1; W0_Addr2 = 5'(i);
            W0_Data2 = (i == 0) ? 32'h1 : 32'h11 * 32'(i);
            tick();
        end
        idle();
        R_Addr2 = {5'd1, 5'd2, 5'd0, 5'd3};
        sb.push_back('{name: "nrd4_p0_r3", dut: 1, port: 0, data: 32'h33, busy: 1'b0});
        sb.push_back('{name: "nrd4_p1_r0", dut: 1, port: 1, data: 32'h1,  busy: 1'b0});
        sb.push_back('{name: "nrd4_p2_r2", dut: 1, port: 2, data: 32'h22, busy: 1'b0});
        sb.push_back('{name: "nrd4_p3_r1", dut: 1, port: 3, data: 32'h11, busy: 1'b0});
        tick();

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
